// File: rtl/king_pkg.sv
// Shared definitions for the KingProcessor execute-stage blocks.
//   XLEN       : datapath width
//   REG_ADDR_W : register bank address width
//   op_e       : multiply/divide operation encodings
//   md_state_e : mul_div_unit FSM states
package king_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIV  = 2'b10,
        OP_REM  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the iterative multiply/divide datapath (combinational).
//   is_div : 0 = shift-add multiply step, 1 = restoring divide step
//   hi, lo : current 64-bit accumulator {hi, lo} ({rem, quo} for divide)
//   opnd   : multiplicand (multiply) or divisor (divide)
//   hi_nxt, lo_nxt : accumulator after this iteration
module mul_div_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0]   sum;     // hi + multiplicand, carry kept
    logic [WIDTH:0]   shifted; // {rem, quo msb}, can exceed WIDTH bits
    logic [WIDTH+1:0] diff;    // trial subtraction, msb is the borrow

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, opnd};

        hi_nxt = '0;
        lo_nxt = '0;
        if (!is_div) begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end else if (!diff[WIDTH+1]) begin
            // remainder is below the divisor, so the low WIDTH bits hold it
            hi_nxt = diff[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_nxt = shifted[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit unsigned multiply/divide unit. Latches operands on start,
// runs 32 iterations, then writes the result to the register bank for one
// cycle.
//   clk, reset            : clock, synchronous active-high reset
//   start, op             : request and operation (MUL/MULH/DIV/REM)
//   operand_a, operand_b  : multiplicand/dividend, multiplier/divisor
//   dest_reg              : destination register number
//   busy                  : high while RUN or DONE
//   done, wr_en           : one-cycle result-valid / write enable
//   result, wr_addr       : write data (held until next done) and address
//   div_zero              : DIV/REM with zero divisor, valid with done
//
// state   | meaning
// --------+---------------------------------------------------
// ST_IDLE | waiting for start
// ST_RUN  | one datapath iteration per cycle, counter 0..ITER-1
// ST_DONE | result registered, write port active for one cycle
module mul_div_unit
    import king_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [WIDTH-1:0]      operand_a,
    input  logic [WIDTH-1:0]      operand_b,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic                  div_zero
);

    localparam int CNT_W = $clog2(ITER);

    md_state_e        state;
    op_e              op_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd_q;   // multiplicand for MUL*, divisor for DIV/REM
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .is_div (op_q[1]),
        .hi     (hi),
        .lo     (lo),
        .opnd   (opnd_q),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            op_q     <= OP_MUL;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_en    <= 1'b0;
            div_zero <= 1'b0;
            result   <= '0;
            wr_addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done     <= 1'b0;
                    wr_en    <= 1'b0;
                    div_zero <= 1'b0;
                    if (start) begin
                        op_q    <= op_e'(op);
                        wr_addr <= dest_reg;
                        cnt     <= '0;
                        hi      <= '0;
                        busy    <= 1'b1;
                        // multiply: lo holds the multiplier; divide: lo holds the dividend
                        lo      <= op[1] ? operand_a : operand_b;
                        opnd_q  <= op[1] ? operand_b : operand_a;
                        if (op[1] && (operand_b == '0)) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            wr_en    <= 1'b1;
                            div_zero <= 1'b1;
                            result   <= op[0] ? operand_a : '1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ITER - 1)) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        wr_en  <= 1'b1;
                        // MULH and REM take the upper half, MUL and DIV the lower
                        result <= op_q[0] ? hi_nxt : lo_nxt;
                    end
                end

                ST_DONE: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    wr_en    <= 1'b0;
                    div_zero <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  dest_reg;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        div_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .dest_reg  (dest_reg),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .div_zero  (div_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic on 64-bit values.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, ".busy"},     32'(busy),     32'd0);
        chk({tag, ".done"},     32'(done),     32'd0);
        chk({tag, ".wr_en"},    32'(wr_en),    32'd0);
        chk({tag, ".div_zero"}, 32'(div_zero), 32'd0);
        chk({tag, ".result"},   result,        32'd0);
        chk({tag, ".wr_addr"},  32'(wr_addr),  32'd0);
    endtask

    // Issue one request and watch a fixed 40-cycle window after the start edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input bit inject, input string tag);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        int          dones;
        int          wr_pulses;
        bit          busy_gap;
        exp       = ref_result(o, a, b);
        exp_lat   = (o[1] && b == 0) ? 1 : 33;
        lat       = 0;
        dones     = 0;
        wr_pulses = 0;
        busy_gap  = 1'b0;

        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b; dest_reg = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        operand_a = $urandom; operand_b = $urandom; dest_reg = 5'($urandom);

        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (inject) begin
                start = (c == 10 || c == 20);
                op = $urandom_range(0, 3);
                operand_a = $urandom; operand_b = $urandom; dest_reg = 5'($urandom);
            end
            if (wr_en) wr_pulses++;
            if (done) begin
                dones++;
                if (lat == 0) begin
                    lat = c;
                    chk({tag, ".result"},   result,        exp);
                    chk({tag, ".wr_en"},    32'(wr_en),    32'd1);
                    chk({tag, ".wr_addr"},  32'(wr_addr),  32'(d));
                    chk({tag, ".div_zero"}, 32'(div_zero), 32'(o[1] && b == 0));
                end
            end else if (lat == 0 && !busy) begin
                busy_gap = 1'b1;
            end
        end
        start = 1'b0;
        chk({tag, ".latency"},   32'(lat),       32'(exp_lat));
        chk({tag, ".dones"},     32'(dones),     32'd1);
        chk({tag, ".wr_pulses"}, 32'(wr_pulses), 32'd1);
        chk({tag, ".busy_gap"},  32'(busy_gap),  32'd0);
        chk({tag, ".hold"},      result,         exp);
        chk({tag, ".idle_busy"}, 32'(busy),      32'd0);
    endtask

    initial begin
        int          wr_seen;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1; start = 1'b0; op = 2'b00;
        operand_a = '0; operand_b = '0; dest_reg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        run_op(2'b00, 32'd7, 32'd6, 5'd5, 1'b0, "mul_7x6");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0, "mulh_max");
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0, "mul_max");
        run_op(2'b10, 32'd100, 32'd7, 5'd3, 1'b0, "div_100_7");
        run_op(2'b11, 32'd100, 32'd7, 5'd4, 1'b0, "rem_100_7");
        run_op(2'b10, 32'd5, 32'd9, 5'd6, 1'b0, "div_5_9");
        run_op(2'b11, 32'd5, 32'd9, 5'd7, 1'b0, "rem_5_9");
        run_op(2'b10, 32'd123, 32'd0, 5'd8, 1'b0, "div_by_0");
        run_op(2'b11, 32'd123, 32'd0, 5'd9, 1'b0, "rem_by_0");
        run_op(2'b00, 32'd0, 32'd12345, 5'd0, 1'b0, "mul_dest0");
        run_op(2'b00, 32'hDEAD_BEEF, 32'h1234_5678, 5'd17, 1'b1, "mul_ignore_start");

        // Reset part-way through a divide: no write may ever appear.
        @(negedge clk);
        start = 1'b1; op = 2'b10; operand_a = 32'd1000; operand_b = 32'd3; dest_reg = 5'd12;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (16) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_mid_div");
        wr_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (wr_en) wr_seen++;
        end
        chk("reset_mid_div.no_write", 32'(wr_seen), 32'd0);
        run_op(2'b00, 32'd3, 32'd3, 5'd10, 1'b0, "mul_after_reset");

        // Reset and start on the same edge: reset wins.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op = 2'b00; operand_a = 32'd2; operand_b = 32'd2;
        @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_vs_start");
        @(posedge clk);
        @(negedge clk);
        chk("reset_vs_start.still_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            run_op(ro, ra, rb, 5'($urandom), 1'b0, $sformatf("rand%0d_op%0d", i, ro));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit unsigned multiply/divide unit for the KingProcessor execute stage. It takes the two read operands from the data register bank and a destination register number, runs a 32-iteration shift-add multiply or restoring divide, and drives the bank's write port (write enable, register address, data) for exactly one cycle when the result is ready. The integer ALU path is untouched; the control unit stalls issue while `busy` is high.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is supported.
- `ITER`, 32: iteration count. Must equal `WIDTH`.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation: 00 MUL (low 32 bits of product), 01 MULH (high 32 bits), 10 DIV (quotient), 11 REM (remainder). All unsigned.
- `operand_a`  in  32  multiplicand / dividend (register bank read port 1).
- `operand_b`  in  32  multiplier / divisor (register bank read port 2).
- `dest_reg`  in  5  destination register number.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle result-valid pulse.
- `result`  out  32  selected result; holds its value until the next `done`.
- `wr_en`  out  1  register bank write enable; equals `done`.
- `wr_addr`  out  5  latched `dest_reg`.
- `div_zero`  out  1  high with `done` when a DIV/REM ran with divisor 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with `start`=1:
  - latch `op`, `operand_a`, `operand_b` and `dest_reg`; clear the iteration counter.
  - DIV/REM with `operand_b`=0 goes directly to DONE. Otherwise go to RUN.
- RUN: one iteration per cycle. After iteration `ITER`-1 (counter 31), go to DONE.
  - MUL/MULH: 64-bit accumulator {hi, lo}, with lo preloaded with the multiplier. Each cycle: if lo[0], add the multiplicand to hi with carry kept in a 33-bit sum; then shift {carry, hi, lo} right by 1.
  - DIV/REM: 64-bit {rem, quo}, with quo preloaded with the dividend. Each cycle: shift left by 1, trial-subtract the divisor from rem (33-bit); if no borrow, keep the difference and set quo[0]=1.
- DONE: `done`=`wr_en`=1 for one cycle, `result` updated, then back to IDLE.
- Divide by zero: quotient = 32'hFFFFFFFF, remainder = `operand_a`, `div_zero`=1.
- `dest_reg`=0 is still written out; the register bank discards writes to register 0.
- `start` in RUN or DONE is ignored: no queueing, no restart.
- `operand_*` may change after the start cycle; the latched copies are used.

## Timing
- Start sampled at rising edge k:
  - `busy`=1 from k+1.
  - `done` high during cycle k+33, i.e. the 33rd edge after k leaves DONE.
  - IDLE again after edge k+34, so a new `start` can be accepted at edge k+34.
- Divide-by-zero latency: `done` during cycle k+1.
- `wr_en`, `wr_addr` and `result` are registered. They are stable for the whole DONE cycle, so the register bank's falling-edge write lands in that same cycle.
- Back-to-back requests: minimum issue spacing is 34 cycles (2 for divide-by-zero).
- Reset (any state, including mid-RUN):
  - next edge goes to IDLE; the in-flight operation is discarded and no write is issued.
  - `busy`, `done`, `wr_en`, `div_zero` = 0; `result` = 0; `wr_addr` = 0; counter = 0.
- Reset wins over a simultaneous `start`.

## Structure
- Shared package `king_pkg`: op encodings (`OP_MUL`, `OP_MULH`, `OP_DIV`, `OP_REM`), `XLEN`=32, `REG_ADDR_W`=5, state enum.
- Single module. An optional sub-module `mul_div_step` holds the combinational one-iteration datapath (add-shift and subtract-shift). The FSM, counter and latches stay in `mul_div_unit`.

## Test plan
- MUL 7 × 6, dest 5 -> `done` exactly 33 cycles after start; `result`=42; `wr_en`=1 for one cycle; `wr_addr`=5.
- MULH 32'hFFFFFFFF × 32'hFFFFFFFF -> `result`=32'hFFFFFFFE. MUL of the same operands -> `result`=32'h00000001.
- DIV 100 / 7 -> 14; REM 100 / 7 -> 2; DIV 5 / 9 -> 0; REM 5 / 9 -> 5.
- DIV 123 / 0 -> `done` one cycle after start; `result`=32'hFFFFFFFF; `div_zero`=1. REM 123 / 0 -> `result`=123.
- `start` pulsed at cycles 10 and 20 of a running MUL, with operands changed -> exactly one `done`, original result, `busy` continuous.
- Reset at iteration 15 of a DIV -> next cycle IDLE with all outputs 0, no `wr_en` ever. A new MUL 3 × 3 issued after reset -> 9.
